// File: rtl/nettlp_tx_sched.sv
// NetTLP transmit scheduler: round-robin packet arbitration between two TLP streams,
// then emits the Ethernet/IPv4/UDP/NetTLP header followed by the granted TLP beats.
module nettlp_tx_sched #(
    parameter logic [7:0]  IP_TTL       = 8'd64,
    parameter logic [15:0] UDP_PORT_CH0 = 16'h3000,
    parameter logic [15:0] UDP_PORT_CH1 = 16'h4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic [47:0] mac_dst,
    input  logic [47:0] mac_src,
    input  logic [31:0] ip_saddr,
    input  logic [31:0] ip_daddr,
    input  logic [31:0] tstamp,
    input  logic        s0_tvalid,
    output logic        s0_tready,
    input  logic [63:0] s0_tdata,
    input  logic [7:0]  s0_tkeep,
    input  logic        s0_tlast,
    input  logic [10:0] s0_tlp_len,
    input  logic        s1_tvalid,
    output logic        s1_tready,
    input  logic [63:0] s1_tdata,
    input  logic [7:0]  s1_tkeep,
    input  logic        s1_tlast,
    input  logic [10:0] s1_tlp_len,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [63:0] m_tdata,
    output logic [7:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic [9:0]  seq_num
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_HDR,
        ST_BODY
    } state_t;

    state_t      state_q, state_d;
    logic        ch_q, ch_d;
    logic        last_grant_q, last_grant_d;
    logic [9:0]  seq_q, seq_d;
    logic [10:0] tlp_len_q, tlp_len_d;
    logic [31:0] tstamp_q, tstamp_d;
    logic [15:0] tot_len_q, tot_len_d;
    logic [15:0] udp_len_q, udp_len_d;
    logic [15:0] csum_q, csum_d;
    logic [2:0]  beat_q, beat_d;

    logic        grant_req;
    logic        grant_ch;
    logic [15:0] ip_id;
    logic [15:0] udp_port;
    logic [15:0] tot_len_calc;
    logic [15:0] udp_len_calc;
    logic [19:0] csum_sum;
    logic [16:0] csum_fold1;
    logic [15:0] csum_fold2;
    logic [63:0] hdr_word;

    // Contention goes to the channel that did not win last time.
    assign grant_req = tx_en && (s0_tvalid || s1_tvalid);
    assign grant_ch  = (s0_tvalid && s1_tvalid) ? ~last_grant_q : s1_tvalid;

    assign ip_id        = {6'b0, seq_q};
    assign udp_port     = ch_q ? UDP_PORT_CH1 : UDP_PORT_CH0;
    assign tot_len_calc = {5'b0, tlp_len_q} + 16'd34;
    assign udp_len_calc = {5'b0, tlp_len_q} + 16'd14;

    // Nine 16-bit terms fit in 20 bits; two end-around folds always suffice.
    assign csum_sum = 20'h04500 + {4'b0, tot_len_calc} + {4'b0, ip_id} + 20'h04000
                    + {4'b0, IP_TTL, 8'h11}
                    + {4'b0, ip_saddr[31:16]} + {4'b0, ip_saddr[15:0]}
                    + {4'b0, ip_daddr[31:16]} + {4'b0, ip_daddr[15:0]};
    assign csum_fold1 = {1'b0, csum_sum[15:0]} + {13'b0, csum_sum[19:16]};
    assign csum_fold2 = csum_fold1[15:0] + {15'b0, csum_fold1[16]};

    always_comb begin
        hdr_word = '0;
        case (beat_q)
            3'd0:    hdr_word = {mac_dst, mac_src[47:32]};
            3'd1:    hdr_word = {mac_src[31:0], 16'h0800, 8'h45, 8'h00};
            3'd2:    hdr_word = {tot_len_q, ip_id, 16'h4000, IP_TTL, 8'h11};
            3'd3:    hdr_word = {csum_q, ip_saddr, ip_daddr[31:16]};
            3'd4:    hdr_word = {ip_daddr[15:0], udp_port, udp_port, udp_len_q};
            3'd5:    hdr_word = {16'h0000, 6'b0, seq_q, tstamp_q};
            default: hdr_word = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        last_grant_d = last_grant_q;
        seq_d        = seq_q;
        tlp_len_d    = tlp_len_q;
        tstamp_d     = tstamp_q;
        tot_len_d    = tot_len_q;
        udp_len_d    = udp_len_q;
        csum_d       = csum_q;
        beat_d       = beat_q;
        m_tvalid     = 1'b0;
        m_tdata      = '0;
        m_tkeep      = '0;
        m_tlast      = 1'b0;
        s0_tready    = 1'b0;
        s1_tready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_req) begin
                    ch_d      = grant_ch;
                    tlp_len_d = grant_ch ? s1_tlp_len : s0_tlp_len;
                    tstamp_d  = tstamp;
                    seq_d     = seq_q + 10'd1;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                tot_len_d = tot_len_calc;
                udp_len_d = udp_len_calc;
                csum_d    = ~csum_fold2;
                beat_d    = 3'd0;
                state_d   = ST_HDR;
            end
            ST_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = hdr_word;
                m_tkeep  = 8'hFF;
                if (m_tready) begin
                    if (beat_q == 3'd5) begin
                        state_d = ST_BODY;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            ST_BODY: begin
                // Framing follows the source tlast only; tlp_len is never checked here.
                if (ch_q) begin
                    m_tvalid  = s1_tvalid;
                    m_tdata   = s1_tdata;
                    m_tkeep   = s1_tkeep;
                    m_tlast   = s1_tlast;
                    s1_tready = m_tready;
                    if (s1_tvalid && m_tready && s1_tlast) begin
                        state_d      = ST_IDLE;
                        last_grant_d = 1'b1;
                    end
                end else begin
                    m_tvalid  = s0_tvalid;
                    m_tdata   = s0_tdata;
                    m_tkeep   = s0_tkeep;
                    m_tlast   = s0_tlast;
                    s0_tready = m_tready;
                    if (s0_tvalid && m_tready && s0_tlast) begin
                        state_d      = ST_IDLE;
                        last_grant_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ch_q         <= 1'b0;
            last_grant_q <= 1'b1;
            seq_q        <= '0;
            tlp_len_q    <= '0;
            tstamp_q     <= '0;
            tot_len_q    <= '0;
            udp_len_q    <= '0;
            csum_q       <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            last_grant_q <= last_grant_d;
            seq_q        <= seq_d;
            tlp_len_q    <= tlp_len_d;
            tstamp_q     <= tstamp_d;
            tot_len_q    <= tot_len_d;
            udp_len_q    <= udp_len_d;
            csum_q       <= csum_d;
            beat_q       <= beat_d;
        end
    end

    assign m_tuser = 1'b0;
    assign seq_num = seq_q;

endmodule
